// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, register address width and word/address typedefs.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

endpackage

// File: rtl/riscv_wb_scoreboard.sv
// Per-register pending-write scoreboard for decode RAW-hazard stalls and writeback checking.
// Optional REGFILE_BYPASS_EN: busy drops in the cycle the last pending write retires.
module riscv_wb_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned PEND_W = 2
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      iss_e_i,
  input  reg_addr_t iss_rd_i,
  input  logic      wb_e_i,
  input  reg_addr_t wb_a_i,
  input  reg_addr_t rs1_a_i,
  input  reg_addr_t rs2_a_i,
  output logic      iss_rdy_o,
  output logic      rs1_busy_o,
  output logic      rs2_busy_o,
  output logic      wb_err_o
);

  localparam logic [PEND_W-1:0] PendMax = '1;

  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic              wb_err_q, wb_err_d;

  assign iss_rdy_o = (iss_rd_i == '0) || (pend_q[iss_rd_i] != PendMax);

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
    end
    for (int r = 1; r < NREGS; r++) begin
      inc = iss_e_i && (iss_rd_i == reg_addr_t'(r)) && iss_rdy_o;
      dec = wb_e_i && (wb_a_i == reg_addr_t'(r)) && (pend_q[r] != '0);
      if (inc && !dec) begin
        pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec && !inc) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end
    end
  end

  assign wb_err_d = wb_err_q | (wb_e_i && (wb_a_i != '0) && (pend_q[wb_a_i] == '0));

`ifdef REGFILE_BYPASS_EN
  logic wb_retire_last;
  // A simultaneous issue to the same rd keeps the register pending, so no early release.
  assign wb_retire_last = wb_e_i && (wb_a_i != '0) && (pend_q[wb_a_i] == PEND_W'(1)) &&
                          !(iss_e_i && (iss_rd_i == wb_a_i) && iss_rdy_o);
  assign rs1_busy_o = (rs1_a_i != '0) && (pend_q[rs1_a_i] != '0) &&
                      !(wb_retire_last && (wb_a_i == rs1_a_i));
  assign rs2_busy_o = (rs2_a_i != '0) && (pend_q[rs2_a_i] != '0) &&
                      !(wb_retire_last && (wb_a_i == rs2_a_i));
`else
  assign rs1_busy_o = (rs1_a_i != '0) && (pend_q[rs1_a_i] != '0);
  assign rs2_busy_o = (rs2_a_i != '0) && (pend_q[rs2_a_i] != '0);
`endif

  assign wb_err_o = wb_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
      wb_err_q <= wb_err_d;
    end
  end

endmodule

// File: rtl/riscv_regfile_wb.sv
// Register file x0..x31 with writeback port, two decode read ports and a pending-write scoreboard.
// Optional REGFILE_BYPASS_EN: writeback data is forwarded to rs1_d/rs2_d in the same cycle.
module riscv_regfile_wb
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned PEND_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_e,
  input  logic [4:0]      wb_a,
  input  logic [XLEN-1:0] wb_d,
  input  logic [4:0]      rs1_a,
  output logic [XLEN-1:0] rs1_d,
  output logic            rs1_busy,
  input  logic [4:0]      rs2_a,
  output logic [XLEN-1:0] rs2_d,
  output logic            rs2_busy,
  input  logic            iss_e,
  input  logic [4:0]      iss_rd,
  output logic            iss_rdy,
  output logic            wb_err,
  input  logic [4:0]      dbg_a,
  output logic [XLEN-1:0] dbg_d
);

  // Entry 0 is never written, so reads of x0 return zero without a special case.
  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_e && (wb_a != '0)) begin
      regs_q[wb_a] <= wb_d;
    end
  end

  always_comb begin
    rs1_d = regs_q[rs1_a];
    rs2_d = regs_q[rs2_a];
`ifdef REGFILE_BYPASS_EN
    if (wb_e && (wb_a != '0) && (wb_a == rs1_a)) begin
      rs1_d = wb_d;
    end
    if (wb_e && (wb_a != '0) && (wb_a == rs2_a)) begin
      rs2_d = wb_d;
    end
`endif
  end

  assign dbg_d = regs_q[dbg_a];

  riscv_wb_scoreboard #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk_i      (clk),
    .reset_i    (reset),
    .iss_e_i    (iss_e),
    .iss_rd_i   (iss_rd),
    .wb_e_i     (wb_e),
    .wb_a_i     (wb_a),
    .rs1_a_i    (rs1_a),
    .rs2_a_i    (rs2_a),
    .iss_rdy_o  (iss_rdy),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .wb_err_o   (wb_err)
  );

endmodule
